// File: rtl/legv8_pkg.sv
// ---------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 immediate encode path: the immediate
// format selector, where each format's field sits in the instruction word,
// and the legal value range of each format.
// ---------------------------------------------------------------------------
package legv8_pkg;

   // Immediate format selector; the encoding matches the in_fmt port.
   typedef enum logic [1:0] {
      FMT_I  = 2'd0,
      FMT_D  = 2'd1,
      FMT_B  = 2'd2,
      FMT_CB = 2'd3
   } imm_fmt_e;

   // Field position (LSB) and width inside the 32-bit instruction word.
   localparam int unsigned FMT_I_LSB  = 10;
   localparam int unsigned FMT_I_W    = 12;
   localparam int unsigned FMT_D_LSB  = 12;
   localparam int unsigned FMT_D_W    = 9;
   localparam int unsigned FMT_B_LSB  = 0;
   localparam int unsigned FMT_B_W    = 26;
   localparam int unsigned FMT_CB_LSB = 5;
   localparam int unsigned FMT_CB_W   = 16;

   // Branch immediates are byte offsets to word-aligned targets; the
   // instruction stores them in words, so the low bits are dropped.
   localparam int unsigned BRANCH_SCALE_BITS = 2;

   // Legal ranges of the immediate value for each format.
   localparam logic [63:0]        FMT_I_MAX  = 64'd4095;
   localparam logic [63:0]        FMT_D_MAX  = 64'd511;
   localparam logic [63:0]        FMT_CB_MAX = 64'd262140;
   localparam logic signed [63:0] FMT_B_MIN  = -64'sd134217728;
   localparam logic signed [63:0] FMT_B_MAX  = 64'sd134217724;

   // Keeps the low 'width' bits of 'bits' and moves them to bit 'lsb'.
   function automatic logic [31:0] placeField(input logic [63:0] bits,
                                              input int unsigned width,
                                              input int unsigned lsb);
      logic [63:0] mask;
      mask = (64'd1 << width) - 64'd1;
      return 32'((bits & mask) << lsb);
   endfunction

endpackage

// File: rtl/imm_field_pack.sv
// ---------------------------------------------------------------------------
// imm_field_pack
// Combinational immediate packer: turns a format and a 64-bit immediate into
// the positioned field bits (ready to be OR-merged into a base instruction)
// and an out-of-range / misalignment flag.
//
// Optional feature macro: INST_IMM_PACKER_RANGE_CHECK_EN
//   defined     -> err_o reports illegal or misaligned immediates
//   not defined -> err_o is tied to 0; fields are silently truncated
//
// Ports:
//   fmt_i    in   immediate format (I, D, B, CB)
//   imm_i    in   64-bit immediate value (byte offset for B/CB)
//   field_o  out  field bits already shifted into their word position
//   err_o    out  immediate did not fit or was misaligned
// ---------------------------------------------------------------------------
module imm_field_pack
   import legv8_pkg::*;
(
   input  imm_fmt_e    fmt_i,
   input  logic [63:0] imm_i,
   output logic [31:0] field_o,
   output logic        err_o
);

   logic [63:0] wordOffset;

   assign wordOffset = imm_i >> BRANCH_SCALE_BITS;

   // Field selection: out-of-range values are truncated to the field width,
   // so the word is always well-formed even when err_o is raised.
   always_comb begin
      field_o = '0;
      case (fmt_i)
         FMT_I:  field_o = placeField(imm_i,      FMT_I_W,  FMT_I_LSB);
         FMT_D:  field_o = placeField(imm_i,      FMT_D_W,  FMT_D_LSB);
         FMT_B:  field_o = placeField(wordOffset, FMT_B_W,  FMT_B_LSB);
         FMT_CB: field_o = placeField(wordOffset, FMT_CB_W, FMT_CB_LSB);
         default: field_o = '0;
      endcase
   end

`ifdef INST_IMM_PACKER_RANGE_CHECK_EN
   logic signed [63:0] immSigned;
   logic               misaligned;

   assign immSigned  = $signed(imm_i);
   assign misaligned = (imm_i[1:0] != 2'b00);

   // Range check: I, D and CB are unsigned offsets, B is a signed
   // PC-relative offset; both branch forms need word alignment.
   always_comb begin
      err_o = 1'b0;
      case (fmt_i)
         FMT_I:  err_o = (imm_i > FMT_I_MAX);
         FMT_D:  err_o = (imm_i > FMT_D_MAX);
         FMT_B:  err_o = misaligned || (immSigned < FMT_B_MIN) || (immSigned > FMT_B_MAX);
         FMT_CB: err_o = misaligned || (imm_i > FMT_CB_MAX);
         default: err_o = 1'b0;
      endcase
   end
`else
   // Without checking, the bits above and below the fields are never looked
   // at; they are gathered here so that is visibly intentional.
   logic unusedImmBits;

   assign unusedImmBits = ^{imm_i[63:28], imm_i[1:0]};
   assign err_o         = 1'b0;
`endif

endmodule

// File: rtl/inst_imm_packer.sv
// ---------------------------------------------------------------------------
// inst_imm_packer
// Two-stage pipelined immediate encoder for the LEGv8 instruction loader.
// Stage 1 captures an accepted input together with its packed field and
// error flag; stage 2 holds the merged instruction word presented on out_*.
// A word-address counter supplies out_addr and advances on every delivered
// word; a saturating counter tallies delivered words flagged as errored.
//
// Optional feature macro: INST_IMM_PACKER_RANGE_CHECK_EN
//   defined     -> range/alignment checks drive out_err and err_cnt
//   not defined -> out_err is always 0 and err_cnt stays 0
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   pulse: clears address and error counters
//   in_valid   in   input word present
//   in_ready   out  input accepted this cycle when in_valid is high
//   in_base    in   base instruction (immediate field expected zero)
//   in_fmt     in   0=I, 1=D, 2=B, 3=CB
//   in_imm     in   64-bit immediate
//   out_valid  out  packed word available
//   out_ready  in   consumer takes the word
//   out_word   out  packed instruction word
//   out_addr   out  instruction-memory word address for out_word
//   out_err    out  immediate was out of range or misaligned
//   err_cnt    out  saturating count of errored words delivered
// ---------------------------------------------------------------------------
module inst_imm_packer
   import legv8_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_base,
   input  logic [1:0]          in_fmt,
   input  logic [63:0]         in_imm,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_word,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_cnt
);

   logic              s1Valid_q, s1Valid_d;
   logic [31:0]       s1Base_q,  s1Base_d;
   logic [31:0]       s1Field_q, s1Field_d;
   logic              s1Err_q,   s1Err_d;
   logic              s2Valid_q, s2Valid_d;
   logic [31:0]       s2Word_q,  s2Word_d;
   logic              s2Err_q,   s2Err_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;

   logic        accept;
   logic        s2Load;
   logic        fire;
   logic [31:0] packField;
   logic        packErr;

   imm_field_pack uFieldPack (
      .fmt_i   (imm_fmt_e'(in_fmt)),
      .imm_i   (in_imm),
      .field_o (packField),
      .err_o   (packErr)
   );

   // Handshakes: stage 2 refills whenever its word leaves (or it is empty),
   // and stage 1 may take a new word in the same cycle it hands one on,
   // which gives one word per cycle when the consumer never stalls.
   assign fire     = s2Valid_q && out_ready;
   assign s2Load   = s1Valid_q && (!s2Valid_q || out_ready);
   assign in_ready = !s1Valid_q || s2Load;
   assign accept   = in_valid && in_ready;

   // Next-state for both pipeline stages and the address counter. start
   // beats a simultaneous fire so a new load always begins at address 0.
   always_comb begin
      s1Valid_d = s1Valid_q;
      s1Base_d  = s1Base_q;
      s1Field_d = s1Field_q;
      s1Err_d   = s1Err_q;
      s2Valid_d = s2Valid_q;
      s2Word_d  = s2Word_q;
      s2Err_d   = s2Err_q;
      addr_d    = addr_q;

      if (accept) begin
         s1Valid_d = 1'b1;
         s1Base_d  = in_base;
         s1Field_d = packField;
         s1Err_d   = packErr;
      end else if (s2Load) begin
         s1Valid_d = 1'b0;
      end

      if (s2Load) begin
         s2Valid_d = 1'b1;
         s2Word_d  = s1Base_q | s1Field_q;
         s2Err_d   = s1Err_q;
      end else if (fire) begin
         s2Valid_d = 1'b0;
      end

      if (start) begin
         addr_d = '0;
      end else if (fire) begin
         addr_d = addr_q + ADDR_W'(1);
      end
   end

   // Pipeline and address registers; reset drops any words in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1Valid_q <= 1'b0;
         s1Base_q  <= '0;
         s1Field_q <= '0;
         s1Err_q   <= 1'b0;
         s2Valid_q <= 1'b0;
         s2Word_q  <= '0;
         s2Err_q   <= 1'b0;
         addr_q    <= '0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Base_q  <= s1Base_d;
         s1Field_q <= s1Field_d;
         s1Err_q   <= s1Err_d;
         s2Valid_q <= s2Valid_d;
         s2Word_q  <= s2Word_d;
         s2Err_q   <= s2Err_d;
         addr_q    <= addr_d;
      end
   end

   assign out_valid = s2Valid_q;
   assign out_word  = s2Word_q;
   assign out_err   = s2Err_q;
   assign out_addr  = addr_q;

`ifdef INST_IMM_PACKER_RANGE_CHECK_EN
   logic [ERRCNT_W-1:0] errCnt_q, errCnt_d;

   // Errored-word tally: counts delivered words only, sticks at all-ones,
   // and is cleared by start even when a word is delivered that cycle.
   always_comb begin
      errCnt_d = errCnt_q;
      if (start) begin
         errCnt_d = '0;
      end else if (fire && s2Err_q && (errCnt_q != '1)) begin
         errCnt_d = errCnt_q + ERRCNT_W'(1);
      end
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         errCnt_q <= '0;
      end else begin
         errCnt_q <= errCnt_d;
      end
   end

   assign err_cnt = errCnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_imm_packer.sv
// ---------------------------------------------------------------------------
// tb_inst_imm_packer
// Scoreboard bench for inst_imm_packer. Expected words are pushed when an
// input is accepted and popped when the DUT delivers a word. A small
// counter model tracks the expected address and error count.
// Built with or without INST_IMM_PACKER_RANGE_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_inst_imm_packer;

   localparam int ADDR_W   = 2;
   localparam int ERRCNT_W = 2;
   localparam int ADDR_MOD = 1 << ADDR_W;
   localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;
`ifdef INST_IMM_PACKER_RANGE_CHECK_EN
   localparam bit CHECKS_ON = 1'b1;
`else
   localparam bit CHECKS_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] word;
      logic        err;
   } sbEntry_t;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [31:0]         in_base = '0;
   logic [1:0]          in_fmt = '0;
   logic [63:0]         in_imm = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [31:0]         out_word;
   logic [ADDR_W-1:0]   out_addr;
   logic                out_err;
   logic [ERRCNT_W-1:0] err_cnt;

   sbEntry_t sb[$];
   int       vecCount  = 0;
   int       missCount = 0;
   int       modelAddr = 0;
   int       modelErr  = 0;
   bit       randReady = 1'b0;

   inst_imm_packer #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_base   (in_base),
      .in_fmt    (in_fmt),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_addr  (out_addr),
      .out_err   (out_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
      end
   endtask

   // Reference packing written arithmetically from the field definitions.
   function automatic sbEntry_t modelPack(input logic [31:0] base,
                                          input logic [1:0] fmt,
                                          input logic [63:0] imm);
      sbEntry_t           e;
      logic signed [63:0] s;
      logic               bad;
      s = imm;
      case (fmt)
         2'd0: begin
            e.word = base | 32'((imm % 64'd4096) * 64'd1024);
            bad    = imm > 64'd4095;
         end
         2'd1: begin
            e.word = base | 32'((imm % 64'd512) * 64'd4096);
            bad    = imm > 64'd511;
         end
         2'd2: begin
            e.word = base | 32'((imm / 64'd4) % 64'd67108864);
            bad    = (s < -64'sd134217728) || (s > 64'sd134217724) || (imm % 64'd4 != 0);
         end
         default: begin
            e.word = base | 32'(((imm / 64'd4) % 64'd65536) * 64'd32);
            bad    = (imm > 64'd262140) || (imm % 64'd4 != 0);
         end
      endcase
      e.err = CHECKS_ON && bad;
      return e;
   endfunction

   // Scoreboard monitor, sampling on the falling edge what the next rising
   // edge will act on.
   always @(negedge clk) begin
      sbEntry_t exp;
      if (reset) begin
         sb.delete();
         modelAddr = 0;
         modelErr  = 0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("spurious fire", 1, 0);
            end else begin
               exp = sb.pop_front();
               checkOutput("out_word", out_word, exp.word);
               checkOutput("out_err", out_err, exp.err);
               checkOutput("out_addr", out_addr, modelAddr);
               checkOutput("err_cnt", err_cnt, modelErr);
               if (!start) begin
                  modelAddr = (modelAddr + 1) % ADDR_MOD;
                  if (exp.err && modelErr < ERR_MAX) modelErr++;
               end
            end
         end
         if (start) begin
            modelAddr = 0;
            modelErr  = 0;
         end
         if (in_valid && in_ready) sb.push_back(modelPack(in_base, in_fmt, in_imm));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Offers one word and holds it until accepted; returns the stall count.
   task automatic applyStimulus(input logic [31:0] base, input logic [1:0] fmt,
                                input logic [63:0] imm, output int waits);
      in_base  = base;
      in_fmt   = fmt;
      in_imm   = imm;
      in_valid = 1'b1;
      waits    = 0;
      while (!in_ready && waits < 200) begin
         tick();
         waits++;
      end
      if (!in_ready) begin
         checkOutput("in_ready timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      checkOutput("drain", sb.size(), 0);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int               waits;
      logic [1:0]       bFmt[12];
      logic [63:0]      bImm[12];
      logic [63:0]      rImm;

      bFmt = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
      bImm = '{64'd4095, 64'd4096, -64'sd1, 64'd511, 64'd512,
               64'sd134217724, 64'sd134217728, -64'sd134217728, -64'sd134217732,
               64'd6, 64'd262140, 64'd262144};

      // Reset state.
      repeat (2) tick();
      reset = 1'b0;
      checkOutput("rst out_valid", out_valid, 0);
      checkOutput("rst out_word", out_word, 0);
      checkOutput("rst out_err", out_err, 0);
      checkOutput("rst out_addr", out_addr, 0);
      checkOutput("rst err_cnt", err_cnt, 0);
      checkOutput("rst in_ready", in_ready, 1);

      // I-format with two-cycle latency, then B-format at the next address.
      out_ready = 1'b1;
      applyStimulus(32'h9100_0000, 2'd0, 64'd100, waits);
      checkOutput("lat I N+1", out_valid, 0);
      tick();
      checkOutput("lat I N+2", out_valid, 1);
      checkOutput("I word", out_word, 32'h9101_9000);
      checkOutput("I addr", out_addr, 0);
      tick();
      applyStimulus(32'h1400_0000, 2'd2, -64'sd8, waits);
      tick();
      checkOutput("B word", out_word, 32'h17FF_FFFE);
      checkOutput("B err", out_err, 0);
      checkOutput("B addr", out_addr, 1);
      waitDrain();

      // Errored immediates and error-count saturation.
      pulseStart();
      applyStimulus(32'hF800_0000, 2'd1, 64'd512, waits);
      applyStimulus(32'hB400_0000, 2'd3, 64'd6, waits);
      waitDrain();
      checkOutput("err_cnt two", err_cnt, CHECKS_ON ? 2 : 0);
      applyStimulus(32'h9100_0000, 2'd0, 64'd5000, waits);
      applyStimulus(32'h1400_0000, 2'd2, 64'd6, waits);
      waitDrain();
      checkOutput("err_cnt sat", err_cnt, CHECKS_ON ? ERR_MAX : 0);

      // Backpressure: two words fill the pipe, the third waits.
      pulseStart();
      out_ready = 1'b0;
      applyStimulus(32'h9100_0000, 2'd0, 64'd1, waits);
      checkOutput("bp accept 1", waits, 0);
      applyStimulus(32'h9100_0000, 2'd0, 64'd2, waits);
      checkOutput("bp accept 2", waits, 0);
      in_base  = 32'h9100_0000;
      in_fmt   = 2'd0;
      in_imm   = 64'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checkOutput("bp in_ready", in_ready, 0);
         checkOutput("bp out_valid", out_valid, 1);
         checkOutput("bp hold word", out_word, 32'h9100_0400);
         checkOutput("bp hold addr", out_addr, 0);
         tick();
      end
      out_ready = 1'b1;
      applyStimulus(32'h9100_0000, 2'd0, 64'd3, waits);
      waitDrain();

      // Address wrap over five words, start landing on the fifth delivery.
      pulseStart();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(32'h9100_0000 | 32'(i), 2'd0, 64'(i * 7), waits);
         checkOutput("stream throughput", waits, 0);
      end
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("start addr", out_addr, 0);
      checkOutput("start err_cnt", err_cnt, 0);
      applyStimulus(32'h9100_0000, 2'd0, 64'd9, waits);
      waitDrain();

      // Field boundaries of each format.
      for (int i = 0; i < 12; i++) applyStimulus($urandom, bFmt[i], bImm[i], waits);
      waitDrain();

      // Random words under random backpressure.
      randReady = 1'b1;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 2))
            0:       rImm = {$urandom, $urandom};
            1:       rImm = 64'($urandom_range(0, 300000));
            default: rImm = -64'($urandom_range(0, 140000000));
         endcase
         applyStimulus($urandom, 2'($urandom_range(0, 3)), rImm, waits);
      end
      waitDrain();
      randReady = 1'b0;

      // Reset with two words in flight.
      out_ready = 1'b0;
      applyStimulus(32'h1234_0000, 2'd0, 64'd5, waits);
      applyStimulus(32'h5678_0000, 2'd1, 64'd6, waits);
      reset = 1'b1;
      tick();
      checkOutput("midrst out_valid", out_valid, 0);
      checkOutput("midrst out_addr", out_addr, 0);
      checkOutput("midrst in_ready", in_ready, 1);
      checkOutput("midrst err_cnt", err_cnt, 0);
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      checkOutput("post rst out_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
